// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: the CPU port, the loader/debug port and the memory macro side.
// The slave modport is the arbiter's view. The master modport is the view of the environment that drives it.
interface mem_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          ldr_req;
  logic          ldr_we;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic          ldr_gnt;
  logic          ldr_rvalid;
  logic [DW-1:0] ldr_rdata;
  logic          ldr_done;
  logic          cpu_run;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_done,
    input  mem_rdata,
    output cpu_stall, cpu_rdata, ldr_gnt, ldr_rvalid, ldr_rdata, cpu_run,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_done,
    output mem_rdata,
    input  cpu_stall, cpu_rdata, ldr_gnt, ldr_rvalid, ldr_rdata, cpu_run,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter for a single-port synchronous-read memory shared by the CPU and the loader/debug port.
// The CPU has priority, but the loader is granted after at most MAX_CPU_BURST consecutive CPU grants.
module mem_arbiter #(
  parameter int unsigned AW            = 8,
  parameter int unsigned DW            = 8,
  parameter int unsigned MAX_CPU_BURST = 4,
  parameter int unsigned BOOT_HOLD     = 1
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam logic [0:0] ST_BOOT   = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;
  localparam logic [1:0] TAG_NONE  = 2'd0;
  localparam logic [1:0] TAG_CPU   = 2'd1;
  localparam logic [1:0] TAG_LDR   = 2'd2;
  localparam logic [3:0] BURST_MAX = 4'(MAX_CPU_BURST);

  logic [0:0]    state;
  logic [3:0]    starve_cnt;
  logic [1:0]    tag;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] ldr_rdata_q;
  logic          ldr_sel;
  logic          cpu_sel;
  logic          cpu_ret;
  logic          ldr_ret;

  always_comb begin
    ldr_sel = 1'b0;
    cpu_sel = 1'b0;
    if (state == ST_BOOT) begin
      ldr_sel = bus.ldr_req;
    end else begin
      ldr_sel = bus.ldr_req && (!bus.cpu_req || starve_cnt == BURST_MAX);
      cpu_sel = bus.cpu_req && !ldr_sel;
    end
  end

  // A read returning while reset is held must not be delivered.
  assign cpu_ret = (tag == TAG_CPU) && !reset;
  assign ldr_ret = (tag == TAG_LDR) && !reset;

  assign bus.cpu_stall  = (state == ST_BOOT) || (bus.cpu_req && !cpu_sel);
  assign bus.ldr_gnt    = ldr_sel;
  assign bus.cpu_run    = (state == ST_RUN);
  assign bus.ldr_rvalid = ldr_ret;
  assign bus.cpu_rdata  = cpu_ret ? bus.mem_rdata : cpu_rdata_q;
  assign bus.ldr_rdata  = ldr_ret ? bus.mem_rdata : ldr_rdata_q;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (ldr_sel) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.ldr_we;
      bus.mem_addr  = bus.ldr_addr;
      bus.mem_wdata = bus.ldr_wdata;
    end else if (cpu_sel) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= (BOOT_HOLD != 0) ? ST_BOOT : ST_RUN;
      starve_cnt  <= '0;
      tag         <= TAG_NONE;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      if (state == ST_BOOT && bus.ldr_done) begin
        state <= ST_RUN;
      end

      if (ldr_sel || !bus.ldr_req) begin
        starve_cnt <= '0;
      end else if (cpu_sel && starve_cnt != BURST_MAX) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      if (ldr_sel && !bus.ldr_we) begin
        tag <= TAG_LDR;
      end else if (cpu_sel && !bus.cpu_we) begin
        tag <= TAG_CPU;
      end else begin
        tag <= TAG_NONE;
      end

      if (cpu_ret) begin
        cpu_rdata_q <= bus.mem_rdata;
      end
      if (ldr_ret) begin
        ldr_rdata_q <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand-written reset and boot sequences.
// Instance a: BOOT_HOLD=1, MAX_CPU_BURST=4, with a memory model. Instance b: BOOT_HOLD=0, MAX_CPU_BURST=1.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(8), .DW(8)) a_if ();
  mem_arbiter_if #(.AW(8), .DW(8)) b_if ();

  mem_arbiter #(.AW(8), .DW(8), .MAX_CPU_BURST(4), .BOOT_HOLD(1)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if)
  );
  mem_arbiter #(.AW(8), .DW(8), .MAX_CPU_BURST(1), .BOOT_HOLD(0)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if)
  );

  // Synchronous-read memory: writes land at the end of the issue cycle
  logic [7:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  end
  always @(posedge clk) begin
    if (a_if.mem_en && a_if.mem_we) mem[a_if.mem_addr] <= a_if.mem_wdata;
    if (a_if.mem_en && !a_if.mem_we) a_if.mem_rdata <= mem[a_if.mem_addr];
  end
  initial a_if.mem_rdata = 8'h00;

  typedef struct {
    logic       creq, cwe;
    logic [7:0] caddr, cwd;
    logic       lreq, lwe;
    logic [7:0] laddr, lwd;
    logic       done;
    logic       stall, gnt, run, en, we;
    logic [7:0] addr, wd;
    logic       rv;
    logic [7:0] crd, lrd;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic creq, cwe, input logic [7:0] caddr, cwd,
                     input logic lreq, lwe, input logic [7:0] laddr, lwd, input logic done,
                     input logic stall, gnt, run, en, we, input logic [7:0] addr, wd,
                     input logic rv, input logic [7:0] crd, lrd);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.lreq = lreq; v.lwe = lwe; v.laddr = laddr; v.lwd = lwd; v.done = done;
    v.stall = stall; v.gnt = gnt; v.run = run; v.en = en; v.we = we;
    v.addr = addr; v.wd = wd; v.rv = rv; v.crd = crd; v.lrd = lrd;
    vecs.push_back(v);
  endtask

  task automatic drive_a(input logic creq, cwe, input logic [7:0] caddr, cwd,
                         input logic lreq, lwe, input logic [7:0] laddr, lwd, input logic done);
    a_if.cpu_req = creq; a_if.cpu_we = cwe; a_if.cpu_addr = caddr; a_if.cpu_wdata = cwd;
    a_if.ldr_req = lreq; a_if.ldr_we = lwe; a_if.ldr_addr = laddr; a_if.ldr_wdata = lwd;
    a_if.ldr_done = done;
  endtask

  initial begin
    drive_a(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    b_if.cpu_req = 0; b_if.cpu_we = 0; b_if.cpu_addr = 8'h07; b_if.cpu_wdata = 8'h00;
    b_if.ldr_req = 0; b_if.ldr_we = 0; b_if.ldr_addr = 8'h09; b_if.ldr_wdata = 8'h00;
    b_if.ldr_done = 0; b_if.mem_rdata = 8'h00;

    //   creq cwe caddr cwd   lreq lwe laddr lwd  done | stall gnt run en we addr wd rv crd lrd
    // Boot load with the CPU requesting throughout
    add(1,0,8'h00,8'h00, 1,1,8'h00,8'h11, 0,  1,1,0,1,1,8'h00,8'h11, 0,8'h00,8'h00);
    add(1,0,8'h00,8'h00, 1,1,8'h01,8'h22, 0,  1,1,0,1,1,8'h01,8'h22, 0,8'h00,8'h00);
    add(1,0,8'h00,8'h00, 1,1,8'h02,8'h33, 0,  1,1,0,1,1,8'h02,8'h33, 0,8'h00,8'h00);
    add(1,0,8'h00,8'h00, 1,1,8'h03,8'h44, 0,  1,1,0,1,1,8'h03,8'h44, 0,8'h00,8'h00);
    // Boot exit, then the CPU reads 0x02
    add(1,0,8'h02,8'h00, 0,0,8'h00,8'h00, 1,  1,0,0,0,0,8'h00,8'h00, 0,8'h00,8'h00);
    add(1,0,8'h02,8'h00, 0,0,8'h00,8'h00, 0,  0,0,1,1,0,8'h02,8'h00, 0,8'h00,8'h00);
    add(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,  0,0,1,0,0,8'h00,8'h00, 0,8'h33,8'h00);
    // Loader read with the CPU idle; ldr_done in RUN is ignored
    add(0,0,8'h00,8'h00, 1,0,8'h01,8'h00, 1,  0,1,1,1,0,8'h01,8'h00, 0,8'h33,8'h00);
    add(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,  0,0,1,0,0,8'h00,8'h00, 1,8'h33,8'h22);
    add(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,  0,0,1,0,0,8'h00,8'h00, 0,8'h33,8'h22);
    // CPU write then read of the same address
    add(1,1,8'h10,8'h5A, 0,0,8'h00,8'h00, 0,  0,0,1,1,1,8'h10,8'h5A, 0,8'h33,8'h22);
    add(1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 0,  0,0,1,1,0,8'h10,8'h00, 0,8'h33,8'h22);
    add(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,  0,0,1,0,0,8'h00,8'h00, 0,8'h5A,8'h22);
    // CPU write, loader read of the same address
    add(1,1,8'h10,8'hC3, 0,0,8'h00,8'h00, 0,  0,0,1,1,1,8'h10,8'hC3, 0,8'h5A,8'h22);
    add(0,0,8'h00,8'h00, 1,0,8'h10,8'h00, 0,  0,1,1,1,0,8'h10,8'h00, 0,8'h5A,8'h22);
    add(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,  0,0,1,0,0,8'h00,8'h00, 1,8'h5A,8'hC3);
    // Starvation bound: both requesting, period of 5
    add(1,0,8'h00,8'h00, 1,0,8'h03,8'h00, 0,  0,0,1,1,0,8'h00,8'h00, 0,8'h5A,8'hC3);
    add(1,0,8'h00,8'h00, 1,0,8'h03,8'h00, 0,  0,0,1,1,0,8'h00,8'h00, 0,8'h11,8'hC3);
    add(1,0,8'h00,8'h00, 1,0,8'h03,8'h00, 0,  0,0,1,1,0,8'h00,8'h00, 0,8'h11,8'hC3);
    add(1,0,8'h00,8'h00, 1,0,8'h03,8'h00, 0,  0,0,1,1,0,8'h00,8'h00, 0,8'h11,8'hC3);
    add(1,0,8'h00,8'h00, 1,0,8'h03,8'h00, 0,  1,1,1,1,0,8'h03,8'h00, 0,8'h11,8'hC3);
    add(1,0,8'h00,8'h00, 1,0,8'h03,8'h00, 0,  0,0,1,1,0,8'h00,8'h00, 1,8'h11,8'h44);
    add(1,0,8'h00,8'h00, 1,0,8'h03,8'h00, 0,  0,0,1,1,0,8'h00,8'h00, 0,8'h11,8'h44);
    add(1,0,8'h00,8'h00, 1,0,8'h03,8'h00, 0,  0,0,1,1,0,8'h00,8'h00, 0,8'h11,8'h44);
    add(1,0,8'h00,8'h00, 1,0,8'h03,8'h00, 0,  0,0,1,1,0,8'h00,8'h00, 0,8'h11,8'h44);
    add(1,0,8'h00,8'h00, 1,0,8'h03,8'h00, 0,  1,1,1,1,0,8'h03,8'h00, 0,8'h11,8'h44);
    add(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,  0,0,1,0,0,8'h00,8'h00, 1,8'h11,8'h44);

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_run_a",    a_if.cpu_run,    1'b0);
    chk("rst_stall_a",  a_if.cpu_stall,  1'b1);
    chk("rst_rvalid_a", a_if.ldr_rvalid, 1'b0);
    chk("rst_crd_a",    a_if.cpu_rdata,  8'h00);
    chk("rst_lrd_a",    a_if.ldr_rdata,  8'h00);
    chk("rst_en_a",     a_if.mem_en,     1'b0);
    chk("rst_run_b",    b_if.cpu_run,    1'b1);

    // Instance b: MAX_CPU_BURST=1 alternates CPU and loader
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      reset = 1'b0;
      b_if.cpu_req = 1'b1;
      b_if.ldr_req = 1'b1;
      #1;
      chk($sformatf("b%0d_stall", i), b_if.cpu_stall, (i % 2 == 1));
      chk($sformatf("b%0d_gnt", i),   b_if.ldr_gnt,   (i % 2 == 1));
      chk($sformatf("b%0d_addr", i),  b_if.mem_addr,  (i % 2 == 1) ? 8'h09 : 8'h07);
    end
    b_if.cpu_req = 1'b0;
    b_if.ldr_req = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive_a(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd,
              vecs[i].lreq, vecs[i].lwe, vecs[i].laddr, vecs[i].lwd, vecs[i].done);
      #1;
      chk($sformatf("v%0d_stall", i),  a_if.cpu_stall,  vecs[i].stall);
      chk($sformatf("v%0d_gnt", i),    a_if.ldr_gnt,    vecs[i].gnt);
      chk($sformatf("v%0d_run", i),    a_if.cpu_run,    vecs[i].run);
      chk($sformatf("v%0d_en", i),     a_if.mem_en,     vecs[i].en);
      chk($sformatf("v%0d_we", i),     a_if.mem_we,     vecs[i].we);
      chk($sformatf("v%0d_addr", i),   a_if.mem_addr,   vecs[i].addr);
      chk($sformatf("v%0d_wdata", i),  a_if.mem_wdata,  vecs[i].wd);
      chk($sformatf("v%0d_rvalid", i), a_if.ldr_rvalid, vecs[i].rv);
      chk($sformatf("v%0d_crd", i),    a_if.cpu_rdata,  vecs[i].crd);
      chk($sformatf("v%0d_lrd", i),    a_if.ldr_rdata,  vecs[i].lrd);
    end

    // Reset while a loader read is in flight
    @(negedge clk);
    drive_a(0, 0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h00, 0);
    #1;
    chk("mr_t_gnt", a_if.ldr_gnt, 1'b1);
    @(negedge clk);
    drive_a(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    reset = 1'b1;
    #1;
    chk("mr_t1_rvalid", a_if.ldr_rvalid, 1'b0);
    chk("mr_t1_lrd",    a_if.ldr_rdata,  8'h44);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mr_t2_rvalid", a_if.ldr_rvalid, 1'b0);
    chk("mr_t2_run",    a_if.cpu_run,    1'b0);
    chk("mr_t2_stall",  a_if.cpu_stall,  1'b1);
    chk("mr_t2_en",     a_if.mem_en,     1'b0);
    chk("mr_t2_lrd",    a_if.ldr_rdata,  8'h00);
    chk("mr_t2_crd",    a_if.cpu_rdata,  8'h00);

    // ldr_done together with a loader write in BOOT
    @(negedge clk);
    drive_a(1, 0, 8'h05, 8'h00, 1, 1, 8'h05, 8'h99, 1);
    #1;
    chk("dr_gnt",   a_if.ldr_gnt,   1'b1);
    chk("dr_stall", a_if.cpu_stall, 1'b1);
    chk("dr_we",    a_if.mem_we,    1'b1);
    chk("dr_run",   a_if.cpu_run,   1'b0);
    @(negedge clk);
    drive_a(1, 0, 8'h05, 8'h00, 1, 0, 8'h00, 8'h00, 0);
    #1;
    chk("dr1_run",   a_if.cpu_run,   1'b1);
    chk("dr1_stall", a_if.cpu_stall, 1'b0);
    chk("dr1_gnt",   a_if.ldr_gnt,   1'b0);
    chk("dr1_addr",  a_if.mem_addr,  8'h05);
    @(negedge clk);
    drive_a(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    #1;
    chk("dr2_crd", a_if.cpu_rdata, 8'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
